// File: rtl/reset_sequencer.sv
// Staged SoC reset sequencer: stretches any reset trigger, then releases channels
// one at a time in index order, and latches the cause of the last reset.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int STRETCH     = 16,
    parameter int STAGE_GAP   = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int WDT_TIMEOUT = 1000000,
    parameter int WDT_WIDTH   = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ext_rst_n_i,
    input  logic              soft_rst_i,
    input  logic              wdt_en_i,
    input  logic              wdt_kick_i,
    output logic [NUM_CH-1:0] rst_o,
    output logic              ready_o,
    output logic [1:0]        rst_cause_o
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_WIDTH-1:0] STRETCH_END = CNT_WIDTH'(STRETCH - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_END     = CNT_WIDTH'(STAGE_GAP - 1);
    localparam logic [WDT_WIDTH-1:0] WDT_END     = WDT_WIDTH'(WDT_TIMEOUT - 1);
    localparam longint CNT_MAX = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]     idx;
    logic [WDT_WIDTH-1:0] wdt;
    logic                 sync1, sync2;
    logic                 ext_trig, wdt_exp, trig;

    // Pad request is asynchronous; synchroniser idles high (no request).
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ext_rst_n_i;
            sync2 <= sync1;
        end
    end

    // A kick on the terminal count suppresses expiry.
    always_comb begin
        ext_trig = ~sync2;
        wdt_exp  = (state == RUN) && wdt_en_i && !wdt_kick_i && (wdt == WDT_END);
        trig     = ext_trig | wdt_exp | soft_rst_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HOLD;
            cnt         <= '0;
            idx         <= '0;
            wdt         <= '0;
            rst_o       <= '1;
            ready_o     <= 1'b0;
            rst_cause_o <= 2'b00;
        end else if (trig) begin
            state   <= HOLD;
            cnt     <= '0;
            idx     <= '0;
            wdt     <= '0;
            rst_o   <= '1;
            ready_o <= 1'b0;
            if (ext_trig)     rst_cause_o <= 2'b01;
            else if (wdt_exp) rst_cause_o <= 2'b11;
            else              rst_cause_o <= 2'b10;
        end else begin
            case (state)
                HOLD: begin
                    wdt <= '0;
                    if (cnt == STRETCH_END) begin
                        cnt      <= '0;
                        rst_o[0] <= 1'b0;
                        if (NUM_CH == 1) begin
                            state   <= RUN;
                            ready_o <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            idx   <= IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    wdt <= '0;
                    if (cnt == GAP_END) begin
                        cnt        <= '0;
                        rst_o[idx] <= 1'b0;
                        idx        <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state   <= RUN;
                            ready_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!wdt_en_i || wdt_kick_i) wdt <= '0;
                    else                         wdt <= wdt + 1'b1;
                end
                default: state <= HOLD;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        assert (CNT_MAX <= (longint'(1) << CNT_WIDTH) &&
                longint'(WDT_TIMEOUT) <= (longint'(1) << WDT_WIDTH))
            else $error("reset_sequencer: CNT_WIDTH or WDT_WIDTH too small");
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: scenario tasks queue expected snapshots keyed by
// edge number and compare them as the edges pass.
module tb_reset_sequencer;
    logic       clock = 1'b0, reset = 1'b1, ext_rst_n_i = 1'b1, soft_rst_i = 1'b0;
    logic       wdt_en_i = 1'b0, wdt_kick_i = 1'b0;
    logic [3:0] rst_o;
    logic       ready_o;
    logic [1:0] rst_cause_o;
    int         checks = 0, errors = 0;

    typedef struct {
        int         k;
        logic [3:0] rst;
        logic       rdy;
        logic [1:0] cause;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #5 clock = ~clock;

    reset_sequencer #(
        .NUM_CH(4), .STRETCH(16), .STAGE_GAP(8), .CNT_WIDTH(8),
        .WDT_TIMEOUT(100), .WDT_WIDTH(24)
    ) dut (
        .clock(clock), .reset(reset), .ext_rst_n_i(ext_rst_n_i), .soft_rst_i(soft_rst_i),
        .wdt_en_i(wdt_en_i), .wdt_kick_i(wdt_kick_i), .rst_o(rst_o), .ready_o(ready_o),
        .rst_cause_o(rst_cause_o)
    );

    task automatic push(input int k, input logic [3:0] r, input logic rdy, input logic [1:0] c);
        exp_t x;
        x.k = k; x.rst = r; x.rdy = rdy; x.cause = c;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({rst_o, ready_o, rst_cause_o} !== {4'hF, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset got rst=%b rdy=%b cause=%b want 1111/0/00", rst_o, ready_o, rst_cause_o);
        end
    endtask

    task automatic test_power_on();
        push(15, 4'hF, 0, 0); push(16, 4'hE, 0, 0); push(23, 4'hE, 0, 0); push(24, 4'hC, 0, 0);
        push(31, 4'hC, 0, 0); push(32, 4'h8, 0, 0); push(39, 4'h8, 0, 0); push(40, 4'h0, 1, 0);
        push(45, 4'h0, 1, 0);
        reset = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL power_on k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL power_on leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_soft();
        push(5, 4'h0, 1, 0); push(6, 4'hF, 0, 2); push(21, 4'hF, 0, 2); push(22, 4'hE, 0, 2);
        push(30, 4'hC, 0, 2); push(38, 4'h8, 0, 2); push(45, 4'h8, 0, 2); push(46, 4'h0, 1, 2);
        push(50, 4'h0, 1, 2);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL soft k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
            if (k == 5) soft_rst_i = 1'b1;
            if (k == 6) soft_rst_i = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL soft leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ext_in_release();
        push(2, 4'hF, 0, 2); push(26, 4'hC, 0, 2); push(30, 4'hC, 0, 2); push(31, 4'hF, 0, 1);
        push(40, 4'hF, 0, 1); push(50, 4'hF, 0, 1); push(65, 4'hF, 0, 1); push(66, 4'hE, 0, 1);
        push(74, 4'hC, 0, 1); push(90, 4'h0, 1, 1);
        for (int k = 1; k <= 92; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL ext_release k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
            if (k == 1)  soft_rst_i  = 1'b1;
            if (k == 2)  soft_rst_i  = 1'b0;
            if (k == 28) ext_rst_n_i = 1'b0;
            if (k == 48) ext_rst_n_i = 1'b1;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL ext_release leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_watchdog();
        bit dropped = 1'b0;
        push(41, 4'h8, 0, 2); push(42, 4'h0, 1, 2); push(141, 4'h0, 1, 2); push(142, 4'hF, 0, 3);
        push(181, 4'h8, 0, 3); push(182, 4'h0, 1, 3); push(1182, 4'h0, 1, 3);
        wdt_en_i = 1'b1;
        for (int k = 1; k <= 1182; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL watchdog k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
            if (k > 182 && ready_o !== 1'b1) dropped = 1'b1;
            if (k == 1) soft_rst_i = 1'b1;
            if (k == 2) soft_rst_i = 1'b0;
            wdt_kick_i = (k > 182 && (k - 182) % 50 == 0);
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL wdt_kicked got ready drop=1 want 0"); end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL watchdog leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_kick_on_expiry();
        push(101, 4'h0, 1, 3); push(150, 4'h0, 1, 3); push(200, 4'h0, 1, 3); push(201, 4'hF, 0, 3);
        wdt_kick_i = 1'b1;
        for (int k = 1; k <= 201; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL kick_expiry k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
            if (k == 1)   wdt_kick_i = 1'b0;
            if (k == 100) wdt_kick_i = 1'b1;
            if (k == 101) wdt_kick_i = 1'b0;
            if (k == 201) wdt_en_i   = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL kick_expiry leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_simultaneous();
        push(4, 4'hF, 0, 3); push(5, 4'hF, 0, 1); push(22, 4'hF, 0, 1); push(23, 4'hE, 0, 1);
        push(31, 4'hC, 0, 1);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL simultaneous k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
            if (k == 2) ext_rst_n_i = 1'b0;
            if (k == 4) soft_rst_i  = 1'b1;
            if (k == 5) begin soft_rst_i = 1'b0; ext_rst_n_i = 1'b1; end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL simultaneous leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid_release();
        push(26, 4'hC, 0, 2); push(28, 4'hC, 0, 2); push(29, 4'hF, 0, 0); push(44, 4'hF, 0, 0);
        push(45, 4'hE, 0, 0);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].k == k) begin
                e = sb.pop_front(); checks++;
                if ({rst_o, ready_o, rst_cause_o} !== {e.rst, e.rdy, e.cause}) begin
                    errors++;
                    $display("FAIL reset_mid k=%0d got rst=%b rdy=%b cause=%b want rst=%b rdy=%b cause=%b",
                             k, rst_o, ready_o, rst_cause_o, e.rst, e.rdy, e.cause);
                end
            end
            if (k == 1)  soft_rst_i = 1'b1;
            if (k == 2)  soft_rst_i = 1'b0;
            if (k == 28) reset      = 1'b1;
            if (k == 29) reset      = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL reset_mid leftover=%0d want 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft();
        test_ext_in_release();
        test_watchdog();
        test_kick_on_expiry();
        test_simultaneous();
        test_reset_mid_release();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised, single-clock reset sequencer for the SoC. It generalises the fixed 16-bit shift-register reset stretcher to N staged reset channels with programmable stretch and inter-stage gap. It adds soft-reset, external-pin and watchdog reset sources, plus a latched reset-cause register. It sits at the SoC top, drives per-domain resets (e.g. bus fabric, SDRAM controller, CPU) in a defined release order, and feeds the cause to a status register.

Parameters:
NUM_CH, 4, number of reset output channels; channel 0 releases first.
STRETCH, 16, cycles all channels stay asserted after the last trigger (>=2).
STAGE_GAP, 8, cycles between release of channel k and channel k+1 (>=1).
CNT_WIDTH, 8, width of the stretch/gap counter; must hold max(STRETCH, STAGE_GAP).
WDT_TIMEOUT, 1000000, watchdog expiry in cycles.
WDT_WIDTH, 24, watchdog counter width; must hold WDT_TIMEOUT.

Ports:
clock  in  1  system clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high master reset.
ext_rst_n_i  in  1  asynchronous pad reset request, active-low; 2-FF synchronised internally.
soft_rst_i  in  1  single-cycle soft-reset request from the CSR block.
wdt_en_i  in  1  watchdog enable.
wdt_kick_i  in  1  watchdog kick pulse; clears the watchdog counter.
rst_o  out  NUM_CH  per-channel reset, active-high; bit k releases k-th.
ready_o  out  1  high when every channel is released (RUN state).
rst_cause_o  out  2  last reset cause: 00 master, 01 ext pin, 10 soft, 11 watchdog.

Behaviour:
- Reset (reset=1): state=HOLD, counter=0, rst_o=all 1s, ready_o=0, rst_cause_o=00, watchdog=0, synchroniser FFs=1 (deasserted).
- States: HOLD -> RELEASE -> RUN. Any trigger in any state forces HOLD.
- HOLD: rst_o all 1s. Counter increments each cycle. At counter==STRETCH-1: clear rst_o[0], clear counter, go RELEASE, idx=1. rst_o[0] therefore first reads 0 exactly STRETCH cycles after the first clock edge with reset=0.
- RELEASE: counter increments. At counter==STAGE_GAP-1: clear rst_o[idx], clear counter, idx++. When idx reaches NUM_CH-1 and it is cleared, go RUN. ready_o rises in the same cycle rst_o[NUM_CH-1] falls. With NUM_CH=1, HOLD goes straight to RUN.
- Released channels never re-assert except through a trigger. No partial re-assertion: a trigger sets all channels to 1 on the next edge.
- Triggers: synchronised ext_rst_n low (level), soft_rst_i=1 (pulse), watchdog expiry. Any trigger: next cycle rst_o=all 1s, ready_o=0, counter=0, idx=0, state=HOLD, watchdog=0.
- ext pin held low: HOLD counter stays at 0, so stretching restarts only after the synchronised pin returns high.
- Trigger during HOLD/RELEASE restarts the full sequence from counter 0.
- Cause priority for simultaneous triggers: ext (01) > watchdog (11) > soft (10). Cause is latched on the trigger edge and holds until the next trigger or master reset.
- Watchdog: counts only in RUN with wdt_en_i=1. It is cleared by wdt_kick_i, by wdt_en_i=0, and outside RUN. At count==WDT_TIMEOUT-1 without a kick, expiry fires and counts as a trigger. A kick on the expiry cycle wins and no expiry occurs.
- Synchroniser latency: 2 cycles from ext_rst_n_i falling to the trigger taking effect, so rst_o asserts on the 3rd edge.
- All counters saturate-free; widths are checked by simulation assertion (CNT_WIDTH, WDT_WIDTH large enough).

Test Plan:
- NUM_CH=4, STRETCH=16, STAGE_GAP=8; release reset at cycle 0 -> rst_o: 1111 until cycle 16, 1110@16, 1100@24, 1000@32, 0000@40; ready_o=1@40; rst_cause_o=00.
- In RUN, pulse soft_rst_i at cycle 100 -> rst_o=1111@101, sequence repeats (0000@141), cause=10.
- In RELEASE (rst_o=1100), drive ext_rst_n_i low for 20 cycles -> rst_o=1111 two cycles later and held. After the pin returns high, rst_o[0] releases 16+2 cycles later; cause=01.
- WDT_TIMEOUT=100, wdt_en_i=1, no kicks from RUN entry -> expiry at RUN cycle 99, rst_o=1111 next cycle, cause=11. Repeat with a kick every 50 cycles -> no reset for 1000 cycles.
- Simultaneous soft_rst_i pulse and ext pin low (synchronised edge coincident) -> single restart, cause=01.
- Assert reset mid-RELEASE -> next cycle rst_o=1111, ready_o=0, cause=00, watchdog=0.
